// File: rtl/aes_block_host.sv
// Host-side feeder/collector for a byte-serial AES core.
// A 128-bit block and key are taken in over a valid/ready request channel. The
// core reads the input bytes through combinational selects driven by its
// out_byte_num. The host pulses idle when the direction changes, then pulses
// start. It reassembles the 16 output bytes and returns them on a valid/ready
// response channel. rsp_err flags a timeout or a byte count other than 16.
module aes_block_host #(
  parameter int TIMEOUT_CYCLES = 512,
  parameter int TO_W           = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_encrypt,
  input  logic [127:0] req_data,
  input  logic [127:0] req_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_encrypt,
  output logic         rsp_err,
  output logic         busy,
  output logic         aes_start,
  output logic         aes_idle,
  output logic         aes_in_encrypt,
  output logic [7:0]   aes_data_in,
  output logic [7:0]   aes_key_in,
  input  logic [3:0]   aes_out_byte_num,
  input  logic         aes_output_valid,
  input  logic [7:0]   aes_data_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MODE  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // The abort fires in the RUN cycle whose incremented count would reach
  // TIMEOUT_CYCLES-1. The response therefore appears TIMEOUT_CYCLES cycles
  // after the start pulse.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);

  state_t          state_q, state_d;
  logic [127:0]    data_q, data_d;
  logic [127:0]    key_q, key_d;
  logic            enc_q, enc_d;
  logic            in_enc_q, in_enc_d;
  logic            mode_known_q, mode_known_d;
  logic [127:0]    rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [TO_W-1:0] to_q, to_d;

  logic            accept_s;
  logic            need_mode_s;
  logic            complete_s;
  logic            timeout_s;
  logic [6:0]      sel_s;

  // Byte n sits at bits [127-8n -: 8], i.e. at offset 120-8n.
  assign sel_s       = 7'd120 - {aes_out_byte_num, 3'b000};
  assign aes_data_in = data_q[sel_s +: 8];
  assign aes_key_in  = key_q[sel_s +: 8];

  assign accept_s    = (state_q == S_IDLE) && req_valid;
  assign need_mode_s = !mode_known_q || (req_encrypt != in_enc_q);
  // The byte counter saturates and never wraps to zero. A nonzero count
  // therefore means that at least one valid byte has been seen.
  assign complete_s  = (state_q == S_RUN) && !aes_output_valid && (cnt_q != 5'd0);
  assign timeout_s   = (state_q == S_RUN) && !complete_s && (to_q == TO_LAST);

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      data_q       <= 128'd0;
      key_q        <= 128'd0;
      enc_q        <= 1'b0;
      in_enc_q     <= 1'b1;
      mode_known_q <= 1'b0;
      rsp_data_q   <= 128'd0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= 5'd0;
      to_q         <= '0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      key_q        <= key_d;
      enc_q        <= enc_d;
      in_enc_q     <= in_enc_d;
      mode_known_q <= mode_known_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = need_mode_s ? S_MODE : S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MODE:  state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (complete_s || timeout_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: latch on accept, capture output bytes and count in RUN
  always_comb begin
    data_d       = data_q;
    key_d        = key_q;
    enc_d        = enc_q;
    in_enc_d     = in_enc_q;
    mode_known_d = mode_known_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    cnt_d        = cnt_q;
    to_d         = to_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          data_d     = req_data;
          key_d      = req_key;
          enc_d      = req_encrypt;
          rsp_data_d = 128'd0;
          rsp_err_d  = 1'b0;
          cnt_d      = 5'd0;
          to_d       = '0;
          // The new direction becomes visible on the core as MODE begins.
          // The direction is held for the rest of the operation.
          if (need_mode_s) begin
            in_enc_d = req_encrypt;
          end else begin
            in_enc_d = in_enc_q;
          end
        end else begin
          data_d = data_q;
        end
      end
      S_MODE: begin
        mode_known_d = 1'b1;
      end
      S_RUN: begin
        to_d = to_q + TO_W'(1);
        if (aes_output_valid) begin
          rsp_data_d[sel_s +: 8] = aes_data_out;
          cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
        end else begin
          cnt_d = cnt_q;
        end
        if (complete_s) begin
          rsp_err_d = (cnt_q != 5'd16);
        end else if (timeout_s) begin
          rsp_err_d = 1'b1;
        end else begin
          rsp_err_d = rsp_err_q;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    aes_start = 1'b0;
    aes_idle  = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_MODE:  aes_idle  = 1'b1;
      S_START: aes_start = 1'b1;
      S_RUN:   busy      = 1'b1;
      S_DONE:  rsp_valid = 1'b1;
      default: busy      = 1'b1;
    endcase
  end

  assign rsp_data       = rsp_data_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_encrypt    = enc_q;
  assign aes_in_encrypt = in_enc_q;

endmodule

// File: tb/tb_aes_block_host.sv
// Directed testbench for aes_block_host. The byte-serial AES core is modelled
// by the bench itself: the bench replays known FIPS-197 results, truncates the
// output, drops it entirely, or emits spurious bytes. The bench then checks
// the host handshakes, pulse timing, reassembly and error flag.
module tb_aes_block_host;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_encrypt = 1'b0;
  logic [127:0] req_data = 128'd0;
  logic [127:0] req_key = 128'd0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         rsp_encrypt;
  logic         rsp_err;
  logic         busy;
  logic         aes_start;
  logic         aes_idle;
  logic         aes_in_encrypt;
  logic [7:0]   aes_data_in;
  logic [7:0]   aes_key_in;
  logic [3:0]   aes_out_byte_num = 4'd0;
  logic         aes_output_valid = 1'b0;
  logic [7:0]   aes_data_out = 8'd0;

  int n_chk  = 0;
  int n_fail = 0;

  aes_block_host #(.TIMEOUT_CYCLES(32), .TO_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_encrypt(req_encrypt),
    .req_data(req_data), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_encrypt(rsp_encrypt), .rsp_err(rsp_err), .busy(busy),
    .aes_start(aes_start), .aes_idle(aes_idle), .aes_in_encrypt(aes_in_encrypt),
    .aes_data_in(aes_data_in), .aes_key_in(aes_key_in),
    .aes_out_byte_num(aes_out_byte_num), .aes_output_valid(aes_output_valid),
    .aes_data_out(aes_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         enc;
    logic [127:0] data;
    logic [127:0] key;
    logic [127:0] res;       // what the modelled core returns
    int           nbytes;    // valid output bytes emitted (0 = never)
    logic         exp_idle;  // mode-change pulse expected
    logic         exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_txn(input vec_t v);
    logic [127:0] exp_data;
    logic [127:0] snap;
    logic         bytes_ok;
    logic         stable_ok;
    int           idx;
    int           cyc;
    // Present the request, with a spurious core byte that IDLE must ignore.
    aes_output_valid = 1'b1; aes_out_byte_num = 4'd3; aes_data_out = 8'hA5;
    req_valid = 1'b1; req_encrypt = v.enc; req_data = v.data; req_key = v.key;
    #1;
    chk("req_ready_idle", req_ready, 1'b1);
    chk("busy_idle", busy, 1'b0);
    tick();
    req_valid = 1'b0; aes_output_valid = 1'b0;
    req_data = ~v.data; req_key = ~v.key;  // latch must not follow the bus
    if (v.exp_idle) begin
      chk("aes_idle_t1", aes_idle, 1'b1);
      chk("aes_start_t1_mode", aes_start, 1'b0);
      chk("in_encrypt_mode", aes_in_encrypt, v.enc);
      tick();
      chk("aes_idle_t2", aes_idle, 1'b0);
    end else begin
      chk("aes_idle_t1_none", aes_idle, 1'b0);
    end
    chk("aes_start", aes_start, 1'b1);
    // Spurious byte during START must be ignored.
    aes_output_valid = 1'b1; aes_out_byte_num = 4'd0; aes_data_out = 8'h5A;
    tick();
    aes_output_valid = 1'b0;
    exp_data = 128'd0;
    if (v.nbytes == 0) begin
      cyc = 1;
      while (!rsp_valid && cyc < 100) begin
        tick();
        cyc++;
      end
      chk("timeout_latency", cyc, 32);
    end else begin
      for (int k = 0; k < v.nbytes; k++) begin
        idx = (k * 7) % 16;
        aes_output_valid = 1'b1;
        aes_out_byte_num = idx[3:0];
        aes_data_out = v.res[127-8*idx -: 8];
        exp_data[127-8*idx -: 8] = v.res[127-8*idx -: 8];
        tick();
      end
      aes_output_valid = 1'b0;
      chk("rsp_valid_early", rsp_valid, 1'b0);
      tick();
      chk("rsp_valid_latency", rsp_valid, 1'b1);
    end
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("rsp_encrypt", rsp_encrypt, v.enc);
    chk("in_encrypt_held", aes_in_encrypt, v.enc);
    chk("req_ready_done", req_ready, 1'b0);
    chk("busy_done", busy, 1'b1);
    // Backpressure: hold rsp_ready low and walk the input byte selects.
    snap = rsp_data;
    bytes_ok = 1'b1;
    stable_ok = 1'b1;
    for (int b = 0; b < 16; b++) begin
      aes_out_byte_num = 4'(b);
      #1;
      if (aes_data_in !== v.data[127-8*b -: 8] || aes_key_in !== v.key[127-8*b -: 8]) begin
        bytes_ok = 1'b0;
      end
      tick();
      if (rsp_data !== snap || rsp_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1) begin
        stable_ok = 1'b0;
      end
    end
    chk("input_byte_select", bytes_ok, 1'b1);
    chk("backpressure_hold", stable_ok, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 1'b0);
    chk("busy_after_hs", busy, 1'b0);
    chk("req_ready_after_hs", req_ready, 1'b1);
  endtask

  initial begin
    logic saw_valid;
    vecs[0] = '{enc: 1'b1, data: PT, key: KEY, res: CT, nbytes: 16, exp_idle: 1'b1, exp_err: 1'b0};
    vecs[1] = '{enc: 1'b0, data: CT, key: KEY, res: PT, nbytes: 16, exp_idle: 1'b1, exp_err: 1'b0};
    vecs[2] = '{enc: 1'b0, data: CT, key: KEY, res: PT, nbytes: 16, exp_idle: 1'b0, exp_err: 1'b0};
    vecs[3] = '{enc: 1'b0, data: CT, key: KEY, res: PT, nbytes: 15, exp_idle: 1'b0, exp_err: 1'b1};
    vecs[4] = '{enc: 1'b0, data: CT, key: KEY, res: PT, nbytes: 17, exp_idle: 1'b0, exp_err: 1'b1};
    vecs[5] = '{enc: 1'b1, data: PT, key: KEY, res: CT, nbytes: 0,  exp_idle: 1'b1, exp_err: 1'b1};
    vecs[6] = '{enc: 1'b1, data: PT, key: KEY, res: CT, nbytes: 16, exp_idle: 1'b0, exp_err: 1'b0};
    vecs[7] = '{enc: 1'b1, data: PT, key: KEY, res: CT, nbytes: 16, exp_idle: 1'b1, exp_err: 1'b0};

    // Reset held for two cycles.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_aes_start", aes_start, 1'b0);
    chk("rst_aes_idle", aes_idle, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_encrypt", aes_in_encrypt, 1'b1);
    chk("rst_rsp_data", rsp_data, 128'd0);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i]);
    end

    // Mid-run reset after 8 captured bytes: the result is discarded.
    req_valid = 1'b1; req_encrypt = 1'b1; req_data = PT; req_key = KEY;
    tick();
    req_valid = 1'b0;
    chk("midrst_start", aes_start, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      aes_output_valid = 1'b1;
      aes_out_byte_num = 4'(k);
      aes_data_out = CT[127-8*k -: 8];
      tick();
    end
    aes_output_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_encrypt", aes_in_encrypt, 1'b1);
    chk("midrst_rsp_data", rsp_data, 128'd0);
    chk("midrst_rsp_err", rsp_err, 1'b0);
    chk("midrst_rsp_encrypt", rsp_encrypt, 1'b0);
    saw_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rsp_valid !== 1'b0) begin
        saw_valid = 1'b1;
      end
    end
    chk("midrst_no_rsp", saw_valid, 1'b0);

    // The first request after reset must issue an idle pulse even though the
    // direction matches the reset value of aes_in_encrypt.
    run_txn(vecs[7]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_block_host.md
Name: aes_block_host

Overview:
- Host-side feeder/collector for the byte-serial AES core.
- Accepts a 128-bit block, 128-bit key and direction over a valid/ready request channel.
- Drives the core's start, idle, in_encrypt, data_in and key_in, with input bytes selected by the core's out_byte_num.
- Reassembles the 16 output bytes into a 128-bit word and returns it on a valid/ready response channel with a timeout/error flag.

Parameters:
- TIMEOUT_CYCLES, 512: maximum cycles from aes_start to completion before the operation is aborted with rsp_err.
- TO_W, 10: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; the single clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_encrypt  in  1  1 = encrypt, 0 = decrypt.
- req_data  in  128  plaintext or ciphertext; byte n = bits [127-8n -: 8].
- req_key  in  128  key; same byte order as req_data.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  128  reassembled core output.
- rsp_encrypt  out  1  direction of the returned result.
- rsp_err  out  1  timeout occurred, or byte count ≠ 16.
- busy  out  1  high in every state except IDLE.
- aes_start  out  1  one-cycle start pulse to the core.
- aes_idle  out  1  one-cycle mode-change pulse to the core.
- aes_in_encrypt  out  1  direction to the core; held stable for the whole operation.
- aes_data_in  out  8  byte aes_out_byte_num of the latched block.
- aes_key_in  out  8  byte aes_out_byte_num of the latched key.
- aes_out_byte_num  in  4  byte index from the core.
- aes_output_valid  in  1  core output byte valid.
- aes_data_out  in  8  core output byte.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - FSM = IDLE; req_ready = 1.
  - rsp_valid = 0, rsp_err = 0, rsp_data = 0, rsp_encrypt = 0.
  - aes_start = 0, aes_idle = 0, aes_in_encrypt = 1, busy = 0.
  - Latched block and key = 0; mode_known = 0; byte counter = 0; timeout counter = 0.
- Input byte path: aes_data_in and aes_key_in are combinational byte selects of the latched block/key indexed by aes_out_byte_num. Latched registers change only on request acceptance.
- FSM states: IDLE, MODE, START, RUN, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch data, key and encrypt; clear rsp_data, byte counter and timeout counter.
  - Go to MODE if !mode_known or req_encrypt ≠ aes_in_encrypt; otherwise go to START.
- MODE (1 cycle): aes_idle = 1; aes_in_encrypt = new mode; set mode_known = 1; go to START.
- START (1 cycle): aes_start = 1; go to RUN.
- RUN:
  - Each cycle aes_output_valid = 1: write aes_data_out into rsp_data byte aes_out_byte_num; increment the byte counter (saturating at 31).
  - Completion: first cycle with aes_output_valid = 0 after at least one valid cycle. Go to DONE; rsp_err = (byte counter ≠ 16).
  - Timeout counter increments each RUN cycle. When it reaches TIMEOUT_CYCLES-1 without completion, go to DONE with rsp_err = 1. rsp_data holds whatever was captured.
- DONE:
  - rsp_valid = 1; rsp_data, rsp_encrypt and rsp_err are held stable.
  - On rsp_ready, go to IDLE and clear rsp_valid.
  - req_ready = 0; no new request is accepted in the same cycle as the response handshake.
- Latency, mode unchanged: request accepted at cycle T → aes_start = 1 at T+1.
- Latency, mode changed: aes_idle = 1 at T+1 → aes_start = 1 at T+2.
- Latency, response: rsp_valid rises the cycle after the completion cycle.
- Spurious input: aes_output_valid outside RUN is ignored.
- aes_in_encrypt changes only in MODE.
- Reset mid-operation: all state returns to reset values immediately.
  - Any in-flight result is discarded; no rsp_valid is produced.
  - mode_known = 0, so the next request always issues an aes_idle pulse.

Test Plan:
- Reset check: hold rst 2 cycles, then release → req_ready = 1; rsp_valid = 0, aes_start = 0, aes_idle = 0, busy = 0; aes_in_encrypt = 1.
- FIPS-197 encrypt: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, encrypt = 1, against the real AES core.
  - Response: aes_idle at T+1, aes_start at T+2.
  - rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err = 0, rsp_encrypt = 1.
- Back-to-back: decrypt of the same ciphertext then a second decrypt.
  - First: aes_idle pulse; rsp_data = 00112233445566778899aabbccddeeff.
  - Second: no aes_idle pulse; aes_start at T+1; identical result.
- Response backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid → rsp_data stable, req_ready = 0, busy = 1. Raise rsp_ready → IDLE on the next cycle.
- Timeout: TIMEOUT_CYCLES = 32 with a stub core that never asserts output_valid → rsp_valid with rsp_err = 1 exactly 32 cycles after aes_start. Stub emitting only 15 valid bytes → rsp_err = 1.
- Mid-run reset: assert rst for 1 cycle after 8 output bytes have been captured → no rsp_valid; outputs return to reset values; next request produces an aes_idle pulse and a correct result.
